// File: rtl/compressor_if.sv
// Block-level bus between the word classifier and the byte packer.
// Signal names follow the surrounding compressor datapath.
interface compressor_if;
  logic         wrtEn;
  logic [255:0] dataIn;
  logic [255:0] cprDataIn;
  logic [15:0]  tagIn;
  logic [255:0] dataOut;
  logic [15:0]  tagOut;

  modport master (
    output wrtEn, dataIn, cprDataIn, tagIn,
    input  dataOut, tagOut
  );

  modport slave (
    input  wrtEn, dataIn, cprDataIn, tagIn,
    output dataOut, tagOut
  );
endinterface

// File: rtl/compressor.sv
// Byte packer: keeps the tag-selected leading bytes of each word and
// left-justifies them into a zero-padded, registered 256-bit block.
module compressor (
  input  logic       clk,
  input  logic       reset,
  compressor_if.slave bus
);

  logic [255:0] packed_data;
  logic [255:0] data_q;
  logic [15:0]  tag_q;
  logic [5:0]   offset;
  logic [31:0]  kept;
  logic [2:0]   count;
  logic [31:0]  word;
  logic [1:0]   tag;

  // The raw block travels past this stage untouched; it must never reach the outputs.
  logic unused_data_in;
  assign unused_data_in = ^bus.dataIn;

  always_comb begin
    packed_data = '0;
    offset      = '0;
    kept        = '0;
    count       = '0;
    word        = '0;
    tag         = '0;
    for (int i = 7; i >= 0; i--) begin
      word = bus.cprDataIn[32*i +: 32];
      tag  = bus.tagIn[2*i +: 2];
      case (tag)
        2'b00:   begin kept = '0;                    count = 3'd0; end
        2'b01:   begin kept = {word[31:24], 24'h0};  count = 3'd1; end
        2'b10:   begin kept = {word[31:16], 16'h0};  count = 3'd2; end
        default: begin kept = word;                  count = 3'd4; end
      endcase
      // Running byte offset places this word right after everything packed so far.
      packed_data = packed_data | ({kept, 224'd0} >> {offset, 3'b000});
      offset      = offset + {3'b000, count};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      tag_q  <= '0;
    end else if (bus.wrtEn) begin
      data_q <= packed_data;
      tag_q  <= bus.tagIn;
    end
  end

  assign bus.dataOut = data_q;
  assign bus.tagOut  = tag_q;

endmodule

// File: tb/tb_compressor.sv
// Directed bench for the byte packer: hand-computed vectors, boundary cases,
// hold/reset control, plus a few random blocks against a byte-stream model.
module tb_compressor;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  compressor_if bus ();

  compressor dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-by-byte reference: walks the words and appends kept bytes to a stream.
  function automatic logic [255:0] pack_model(input logic [255:0] d, input logic [15:0] t);
    logic [255:0] r;
    int k;
    int n;
    r = '0;
    k = 0;
    for (int w = 7; w >= 0; w--) begin
      case (t[2*w +: 2])
        2'b00:   n = 0;
        2'b01:   n = 1;
        2'b10:   n = 2;
        default: n = 4;
      endcase
      for (int b = 0; b < n; b++) begin
        r[255-8*k -: 8] = d[32*w+31-8*b -: 8];
        k++;
      end
    end
    return r;
  endfunction

  task automatic check_data(input string name, input logic [255:0] exp_d);
    total++;
    assert (bus.dataOut === exp_d)
    else begin
      bad++;
      $error("FAIL %s dataOut got=%h exp=%h", name, bus.dataOut, exp_d);
    end
  endtask

  task automatic check_tag(input string name, input logic [15:0] exp_t);
    total++;
    assert (bus.tagOut === exp_t)
    else begin
      bad++;
      $error("FAIL %s tagOut got=%h exp=%h", name, bus.tagOut, exp_t);
    end
  endtask

  task automatic drive(input logic en, input logic [255:0] d, input logic [15:0] t);
    bus.wrtEn     = en;
    bus.cprDataIn = d;
    bus.tagIn     = t;
    bus.dataIn    = {8{$urandom()}};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [255:0] full_in;
  logic [255:0] rnd_d;
  logic [15:0]  rnd_t;
  logic [255:0] last_d;
  logic [15:0]  last_t;

  initial begin
    total = 0;
    bad   = 0;
    full_in = 256'h123456789ABCDEF123456789ABCDEF123456789ABCDEF123456789ABCDEF1234;

    reset         = 1'b1;
    bus.wrtEn     = 1'b0;
    bus.dataIn    = 'x;
    bus.cprDataIn = '0;
    bus.tagIn     = '0;
    #1;
    check_data("reset_state", '0);
    check_tag("reset_state", '0);

    @(negedge clk);
    reset = 1'b0;

    // Block 1, L=15, with dataIn left as X
    bus.wrtEn     = 1'b1;
    bus.cprDataIn = 256'h1200_0000_0000_0000_3400_0000_5678_0000_9ABC_DEF1_2300_0000_4567_0000_89AB_CDEF;
    bus.tagIn     = 16'b0100011011011011;
    tick();
    check_data("block1", {120'h123456789ABCDEF123456789ABCDEF, 136'h0});
    check_tag("block1", 16'b0100011011011011);

    // Blocks 2-4 back to back
    drive(1'b1, 256'h1234_0000_5678_0000_9ABC_0000_DE00_0000_F100_0000_2345_0000_6700_0000_0000_0000,
          16'b1010100101100100);
    tick();
    check_data("block2", {88'h123456789ABCDEF1234567, 168'h0});
    check_tag("block2", 16'b1010100101100100);

    drive(1'b1, 256'h0000_0000_0000_0000_3400_0000_5678_0000_0000_0000_9ABC_0000_DE00_0000_F100_0000,
          16'b0000011000100101);
    tick();
    check_data("block3", {56'h3456789ABCDEF1, 200'h0});
    check_tag("block3", 16'b0000011000100101);

    drive(1'b1, {32'h1234_0000, 160'h0, 64'h5678_0000_9ABC_DEF1}, 16'b1000000000001011);
    tick();
    check_data("block4", {64'h123456789ABCDEF1, 192'h0});
    check_tag("block4", 16'b1000000000001011);

    // Extremes
    drive(1'b1, '0, 16'h0000);
    tick();
    check_data("all_zero", '0);
    check_tag("all_zero", 16'h0000);

    drive(1'b1, full_in, 16'hFFFF);
    tick();
    check_data("full_pass", full_in);
    check_tag("full_pass", 16'hFFFF);

    drive(1'b1, {256{1'b1}}, 16'b0101010101010101);
    tick();
    check_data("dropped_ff", {64'hFFFF_FFFF_FFFF_FFFF, 192'h0});
    check_tag("dropped_ff", 16'b0101010101010101);

    // Hold for two cycles with new inputs presented
    drive(1'b0, full_in, 16'hFFFF);
    tick();
    check_data("hold1", {64'hFFFF_FFFF_FFFF_FFFF, 192'h0});
    check_tag("hold1", 16'b0101010101010101);
    drive(1'b0, '0, 16'h1234);
    tick();
    check_data("hold2", {64'hFFFF_FFFF_FFFF_FFFF, 192'h0});
    check_tag("hold2", 16'b0101010101010101);

    // Asynchronous reset between edges, held across an enabled edge
    drive(1'b1, full_in, 16'hFFFF);
    #2;
    reset = 1'b1;
    #1;
    check_data("async_reset", '0);
    check_tag("async_reset", '0);
    tick();
    check_data("reset_held", '0);
    check_tag("reset_held", '0);

    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 256'h1200_0000_0000_0000_3400_0000_5678_0000_9ABC_DEF1_2300_0000_4567_0000_89AB_CDEF,
          16'b0100011011011011);
    tick();
    check_data("post_reset", {120'h123456789ABCDEF123456789ABCDEF, 136'h0});
    check_tag("post_reset", 16'b0100011011011011);

    // Random blocks, consecutive cycles, random dataIn
    for (int n = 0; n < 24; n++) begin
      rnd_d = {8{$urandom()}};
      rnd_t = 16'($urandom());
      drive(1'b1, rnd_d, rnd_t);
      tick();
      last_d = pack_model(rnd_d, rnd_t);
      last_t = rnd_t;
      check_data("random", last_d);
      check_tag("random", last_t);
    end

    drive(1'b0, {8{$urandom()}}, 16'($urandom()));
    tick();
    check_data("final_hold", last_d);
    check_tag("final_hold", last_t);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
